// File: rtl/tanh_backprop_if.sv
// Operand/result handshake bundle for the tanh backward-pass unit.
// The master drives operands and result acceptance; the slave is the gradient block.
interface tanh_backprop_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] err_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] delta_out;
  logic signed [WIDTH-1:0] deriv_out;
  logic                    sat_flag;

  modport master (
    output in_valid, y_in, err_in, out_ready,
    input  in_ready, out_valid, delta_out, deriv_out, sat_flag
  );

  modport slave (
    input  in_valid, y_in, err_in, out_ready,
    output in_ready, out_valid, delta_out, deriv_out, sat_flag
  );
endinterface

// File: rtl/tanh_backprop.sv
// Local tanh gradient: delta = err * (1 - y^2) in signed fixed point.
// One shared signed multiplier is time-multiplexed across the SQ and MUL states.
module tanh_backprop #(
  parameter int WIDTH = 32,
  parameter int FL    = 24
) (
  input  logic          clk,
  input  logic          rst,
  tanh_backprop_if.slave bus
);

  localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-FL-1){1'b0}}, 1'b1, {FL{1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Clamping y to [-1, 1] bounds deriv to [0, 1], so delta can never exceed |err|.
  function automatic logic signed [WIDTH-1:0] clamp_unit(input logic signed [WIDTH-1:0] v);
    if (v > ONE)          return ONE;
    else if (v < NEG_ONE) return NEG_ONE;
    else                  return v;
  endfunction

  function automatic logic is_clamped(input logic signed [WIDTH-1:0] v);
    return (v > ONE) || (v < NEG_ONE);
  endfunction

  // Arithmetic shift floors toward -inf; no rounding is applied.
  function automatic logic signed [WIDTH-1:0] q_shift(input logic signed [2*WIDTH-1:0] p);
    return WIDTH'(p >>> FL);
  endfunction

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] err_q, err_d;
  logic signed [WIDTH-1:0] deriv_q, deriv_d;
  logic                    sat_q, sat_d;
  logic signed [WIDTH-1:0] delta_out_q, delta_out_d;
  logic signed [WIDTH-1:0] deriv_out_q, deriv_out_d;
  logic                    sat_out_q, sat_out_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [WIDTH-1:0]   mul_a;
  logic signed [WIDTH-1:0]   mul_b;
  logic signed [2*WIDTH-1:0] prod;

  always_comb begin
    mul_a = err_q;
    mul_b = deriv_q;
    if (state_q == SQ) begin
      mul_a = y_q;
      mul_b = y_q;
    end
    prod = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    err_d       = err_q;
    deriv_d     = deriv_q;
    sat_d       = sat_q;
    delta_out_d = delta_out_q;
    deriv_out_d = deriv_out_q;
    sat_out_d   = sat_out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          y_d     = clamp_unit(bus.y_in);
          sat_d   = is_clamped(bus.y_in);
          err_d   = bus.err_in;
          state_d = SQ;
        end
      end
      SQ: begin
        deriv_d = ONE - q_shift(prod);
        state_d = MUL;
      end
      // Result registers only change here so they hold through IDLE until the next result.
      MUL: begin
        delta_out_d = q_shift(prod);
        deriv_out_d = deriv_q;
        sat_out_d   = sat_q;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      y_q         <= '0;
      err_q       <= '0;
      deriv_q     <= '0;
      sat_q       <= 1'b0;
      delta_out_q <= '0;
      deriv_out_q <= '0;
      sat_out_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      err_q       <= err_d;
      deriv_q     <= deriv_d;
      sat_q       <= sat_d;
      delta_out_q <= delta_out_d;
      deriv_out_q <= deriv_out_d;
      sat_out_q   <= sat_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.delta_out = delta_out_q;
  assign bus.deriv_out = deriv_out_q;
  assign bus.sat_flag  = sat_out_q;

endmodule
